alu_hazard_scheduler: RTL and testbench
=======================================

// Module: alu_hazard_scheduler
// PURPOSE
// - Pipeline control unit for the shared EX-stage ALU of the 5-stage RISC-V core.
// - Generates forwarding selects for ALU operands A/B, load-use stall bubbles, branch flushes,
//   and sequences multi-cycle ALU ops that occupy EX for MC_CYCLES cycles.
// - Sits beside the datapath. Drives F/D/E/M stall/flush/bubble enables; the ALU decoder drives ALU_control.
// PARAMETERS
// - MC_CYCLES  4  total EX-occupancy cycles of a multi-cycle ALU op (legal range >= 2)
// PORTS
// - clk           in   1   rising-edge clock
// - rst           in   1   synchronous reset, active-low
// - rs1_d, rs2_d  in   5   source regs of instr in D
// - rs1_e, rs2_e  in   5   source regs of instr in E
// - rd_e          in   5   dest reg of instr in E
// - load_e        in   1   instr in E is a load (result_src == memory)
// - mc_start_e    in   1   instr in E is a multi-cycle ALU op
// - pc_src_e      in   1   branch/jump taken in E
// - rd_m, reg_write_m  in  5,1  M-stage dest / write enable
// - rd_w, reg_write_w  in  5,1  W-stage dest / write enable
// - forward_a_e, forward_b_e  out  2  00 = regfile, 01 = W result, 10 = M ALU result
// - stall_f, stall_d, stall_e out  1   hold PC / IF-ID / ID-EX registers
// - flush_d, flush_e          out  1   clear IF-ID / ID-EX registers
// - bubble_m      out  1   insert NOP into EX-MEM register
// - mc_done       out  1   multi-cycle result valid on ALU output this cycle
// - stall_cycles  out  32  stall-cycle count (see CONFIGURATION)
// BEHAVIOUR
// - Reset: while rst==0, every output is 0. At the next edge: state = IDLE, cnt = 0.
//   Reset mid multi-cycle op aborts it, with no mc_done.
// - Forwarding (combinational):
//   - forward_a_e = 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e;
//     else 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e; else 00.
//   - M has priority over W. forward_b_e uses rs2_e with the same rules.
// - lw_hz = load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
// - FSM states: IDLE, MC_BUSY. Counter cnt is $clog2(MC_CYCLES) bits wide.
// - IDLE with mc_start_e=1 (takes priority over pc_src_e and lw_hz):
//   - stall_f = stall_d = stall_e = bubble_m = 1.
//   - next state MC_BUSY; cnt <= MC_CYCLES-2.
// - MC_BUSY with cnt!=0: stall_f/d/e = bubble_m = 1; cnt <= cnt-1.
// - MC_BUSY with cnt==0: mc_done = 1, no stalls, instr advances; next state IDLE.
// - mc_start_e, pc_src_e and lw_hz are ignored in MC_BUSY.
// - Net effect: an op entering E at cycle t gives stalls t..t+MC_CYCLES-2 and mc_done at t+MC_CYCLES-1.
// - IDLE, no mc_start_e:
//   - stall_f = stall_d = lw_hz && !pc_src_e.
//   - flush_e = lw_hz || pc_src_e.
//   - flush_d = pc_src_e.
//   - Branch wins over load-use: D is squashed, so no stall.
// - flush_* are never asserted in the same cycle as stall_e.
// CONFIGURATION
// - Macro ALU_STALL_COUNT_EN.
// - Defined: stall_cycles increments each cycle stall_d==1, saturates at 32'hFFFF_FFFF, reset to 0.
// - Undefined: stall_cycles tied to 32'd0 and no counter flops exist.
// TESTING
// - Forwarding: rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> forward_a_e=10.
//   rd_m=0, same W, rs2_e=5 -> forward_b_e=01.
// - Load-use: load_e=1, rd_e=7, rs2_d=7 -> one cycle of stall_f=stall_d=flush_e=1.
//   rd_e=0 -> no stall.
// - Branch + load-use same cycle: pc_src_e=1, lw_hz=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
// - Multi-cycle, MC_CYCLES=4: mc_start_e=1 at cycle t -> stall_e=bubble_m=1 at t..t+2,
//   mc_done=1 at t+3 only, back to IDLE at t+4.
// - Reset mid-op: rst=0 at t+1 of an MC op -> all outputs 0 that cycle, state IDLE, mc_done never pulses.
// - With ALU_STALL_COUNT_EN: load-use + one MC_CYCLES=4 op -> stall_cycles=4.
//   Without the macro -> stall_cycles stays 0.

Source files
------------

// File: rtl/alu_hazard_if.sv
// Hazard-unit bundle between the pipeline datapath and alu_hazard_scheduler.
// The master modport is the datapath side. It supplies the register fields for
// each stage and receives the stall, flush and forward controls. The slave
// modport is the scheduler.
interface alu_hazard_if;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic [4:0]  rs1_e;
   logic [4:0]  rs2_e;
   logic [4:0]  rd_e;
   logic        load_e;
   logic        mc_start_e;
   logic        pc_src_e;
   logic [4:0]  rd_m;
   logic        reg_write_m;
   logic [4:0]  rd_w;
   logic        reg_write_w;
   logic [1:0]  forward_a_e;
   logic [1:0]  forward_b_e;
   logic        stall_f;
   logic        stall_d;
   logic        stall_e;
   logic        flush_d;
   logic        flush_e;
   logic        bubble_m;
   logic        mc_done;
   logic [31:0] stall_cycles;

   modport master (
      output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, mc_start_e, pc_src_e,
             rd_m, reg_write_m, rd_w, reg_write_w,
      input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
             flush_d, flush_e, bubble_m, mc_done, stall_cycles
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, mc_start_e, pc_src_e,
             rd_m, reg_write_m, rd_w, reg_write_w,
      output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
             flush_d, flush_e, bubble_m, mc_done, stall_cycles
   );
endinterface

// File: rtl/alu_hazard_scheduler.sv
// EX-stage hazard and multi-cycle ALU scheduler for the 5-stage core.
// Optional feature: define ALU_STALL_COUNT_EN to add a saturating 32-bit count
// of cycles with stall_d asserted. Without the macro, stall_cycles is tied to 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | normal flow: forwarding, load-use stall, branch flush
// MC_BUSY | multi-cycle op holds EX; cnt_q counts the stall cycles left
//
// The controls must respond in the same cycle the hazard appears in E/D.
// For this reason the outputs are decoded combinationally from state_q and the
// current stage fields. While rst is low, every output is forced to 0.
module alu_hazard_scheduler #(
   parameter int MC_CYCLES = 4
) (
   input logic           clk,
   input logic           rst,
   alu_hazard_if.slave   hz
);
   localparam int CW = $clog2(MC_CYCLES);
   localparam logic [CW-1:0] CNT_INIT = CW'(MC_CYCLES - 2);

   typedef enum logic {IDLE, MC_BUSY} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            lw_hz;
   logic [1:0]      fwd_a, fwd_b;
   logic            stall_f_o, stall_d_o, stall_e_o;
   logic            flush_d_o, flush_e_o, bubble_m_o, mc_done_o;

   assign lw_hz = hz.load_e && (hz.rd_e != 5'd0) &&
                  ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

   // Next-state and control decode. The M stage wins over W for forwarding.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fwd_a      = 2'b00;
      fwd_b      = 2'b00;
      stall_f_o  = 1'b0;
      stall_d_o  = 1'b0;
      stall_e_o  = 1'b0;
      flush_d_o  = 1'b0;
      flush_e_o  = 1'b0;
      bubble_m_o = 1'b0;
      mc_done_o  = 1'b0;
      if (rst) begin
         if (hz.reg_write_m && hz.rd_m != 5'd0 && hz.rd_m == hz.rs1_e)
            fwd_a = 2'b10;
         else if (hz.reg_write_w && hz.rd_w != 5'd0 && hz.rd_w == hz.rs1_e)
            fwd_a = 2'b01;
         if (hz.reg_write_m && hz.rd_m != 5'd0 && hz.rd_m == hz.rs2_e)
            fwd_b = 2'b10;
         else if (hz.reg_write_w && hz.rd_w != 5'd0 && hz.rd_w == hz.rs2_e)
            fwd_b = 2'b01;
         case (state_q)
            IDLE: begin
               if (hz.mc_start_e) begin
                  stall_f_o  = 1'b1;
                  stall_d_o  = 1'b1;
                  stall_e_o  = 1'b1;
                  bubble_m_o = 1'b1;
                  state_d    = MC_BUSY;
                  cnt_d      = CNT_INIT;
               end else begin
                  // A taken branch squashes D, so a load-use stall is pointless.
                  stall_f_o = lw_hz && !hz.pc_src_e;
                  stall_d_o = lw_hz && !hz.pc_src_e;
                  flush_e_o = lw_hz || hz.pc_src_e;
                  flush_d_o = hz.pc_src_e;
               end
            end
            MC_BUSY: begin
               if (cnt_q != '0) begin
                  stall_f_o  = 1'b1;
                  stall_d_o  = 1'b1;
                  stall_e_o  = 1'b1;
                  bubble_m_o = 1'b1;
                  cnt_d      = cnt_q - 1'b1;
               end else begin
                  mc_done_o = 1'b1;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register; a reset mid-op drops the op without an mc_done pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.forward_a_e = fwd_a;
   assign hz.forward_b_e = fwd_b;
   assign hz.stall_f     = stall_f_o;
   assign hz.stall_d     = stall_d_o;
   assign hz.stall_e     = stall_e_o;
   assign hz.flush_d     = flush_d_o;
   assign hz.flush_e     = flush_e_o;
   assign hz.bubble_m    = bubble_m_o;
   assign hz.mc_done     = mc_done_o;

`ifdef ALU_STALL_COUNT_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of decode-stall cycles.
   always_ff @(posedge clk) begin
      if (!rst)
         stall_cnt_q <= '0;
      else if (stall_d_o && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign hz.stall_cycles = rst ? stall_cnt_q : 32'd0;
`else
   assign hz.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_alu_hazard_scheduler.sv
// Self-checking bench for alu_hazard_scheduler. It runs directed scenarios and
// then randomized traffic. The reference model tracks the number of EX cycles
// an op still needs plus a stall tally.
module tb_alu_hazard_scheduler;
   localparam int MC = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   alu_hazard_if hif ();

   alu_hazard_scheduler #(.MC_CYCLES(MC)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif.slave)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          m_busy   = 0;
   logic [31:0] m_sc     = 32'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (hif.reg_write_m && hif.rd_m != 0 && hif.rd_m == rs) return 2'b10;
      if (hif.reg_write_w && hif.rd_w != 0 && hif.rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [6:0] ctrl_obs();
      return {hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_d,
              hif.flush_e, hif.bubble_m, hif.mc_done};
   endfunction

   task automatic idle_inputs();
      hif.rs1_d = 0; hif.rs2_d = 0; hif.rs1_e = 0; hif.rs2_e = 0; hif.rd_e = 0;
      hif.load_e = 0; hif.mc_start_e = 0; hif.pc_src_e = 0;
      hif.rd_m = 0; hif.reg_write_m = 0; hif.rd_w = 0; hif.reg_write_w = 0;
   endtask

   // Compare the DUT against the model for the current inputs, then advance the model.
   task automatic step();
      logic       lw;
      logic [1:0] fa, fb;
      logic       sf, sd, se, fd, fe, bm, dn;
      #1;
      lw = hif.load_e && hif.rd_e != 0 && (hif.rd_e == hif.rs1_d || hif.rd_e == hif.rs2_d);
      {fa, fb, sf, sd, se, fd, fe, bm, dn} = '0;
      if (rst) begin
         fa = ref_fwd(hif.rs1_e);
         fb = ref_fwd(hif.rs2_e);
         if (m_busy > 1) {sf, sd, se, bm} = 4'b1111;
         else if (m_busy == 1) dn = 1'b1;
         else if (hif.mc_start_e) {sf, sd, se, bm} = 4'b1111;
         else begin
            sf = lw && !hif.pc_src_e;
            sd = sf;
            fe = lw || hif.pc_src_e;
            fd = hif.pc_src_e;
         end
      end
      check("fwd_a", 32'(hif.forward_a_e), 32'(fa));
      check("fwd_b", 32'(hif.forward_b_e), 32'(fb));
      check("ctrl", 32'(ctrl_obs()), 32'({sf, sd, se, fd, fe, bm, dn}));
`ifdef ALU_STALL_COUNT_EN
      check("stall_cycles", hif.stall_cycles, rst ? m_sc : 32'd0);
`else
      check("stall_cycles", hif.stall_cycles, 32'd0);
`endif
      if (!rst) begin
         m_busy = 0;
         m_sc   = 0;
      end else begin
         if (m_busy > 0) m_busy--;
         else if (hif.mc_start_e) m_busy = MC - 1;
         if (sd && m_sc != 32'hFFFF_FFFF) m_sc++;
      end
   endtask

   initial begin
      idle_inputs();
      @(negedge clk);
      // While reset is low, every output must be 0, even if forwarding conditions hold.
      rst = 0;
      hif.rd_m = 5; hif.reg_write_m = 1; hif.rs1_e = 5; hif.mc_start_e = 1;
      step(); check("rst_fwd_a", 32'(hif.forward_a_e), 32'd0);
      check("rst_ctrl", 32'(ctrl_obs()), 32'd0);
      @(negedge clk); step(); @(negedge clk);
      rst = 1; idle_inputs();

      // Forwarding: M has priority over W.
      hif.rd_m = 5; hif.reg_write_m = 1; hif.rd_w = 5; hif.reg_write_w = 1; hif.rs1_e = 5;
      step(); check("dir_fwd_a_m", 32'(hif.forward_a_e), 32'd2); @(negedge clk);
      hif.rd_m = 0; hif.rs1_e = 0; hif.rs2_e = 5;
      step(); check("dir_fwd_b_w", 32'(hif.forward_b_e), 32'd1); @(negedge clk);
      idle_inputs();

      // Load-use hazard.
      hif.load_e = 1; hif.rd_e = 7; hif.rs2_d = 7;
      step(); check("dir_lw", 32'(ctrl_obs()), 32'b1100100); @(negedge clk);
      hif.load_e = 0;
      step(); check("dir_lw_after", 32'(ctrl_obs()), 32'd0); @(negedge clk);
      hif.load_e = 1; hif.rd_e = 0; hif.rs2_d = 0;
      step(); check("dir_lw_x0", 32'(ctrl_obs()), 32'd0); @(negedge clk);

      // A branch and a load-use hazard in the same cycle.
      hif.rd_e = 7; hif.rs1_d = 7; hif.pc_src_e = 1;
      step(); check("dir_br_lw", 32'(ctrl_obs()), 32'b0001100); @(negedge clk);
      idle_inputs();

      // Multi-cycle op with mc_start_e held while EX is occupied.
      hif.mc_start_e = 1; hif.pc_src_e = 1; hif.load_e = 1; hif.rd_e = 3; hif.rs1_d = 3;
      for (int i = 0; i < MC - 1; i++) begin
         step(); check("dir_mc_stall", 32'(ctrl_obs()), 32'b1110010); @(negedge clk);
      end
      step(); check("dir_mc_done", 32'(ctrl_obs()), 32'b0000001); @(negedge clk);
      idle_inputs();
      step(); check("dir_mc_idle", 32'(ctrl_obs()), 32'd0);
`ifdef ALU_STALL_COUNT_EN
      check("dir_stall_cnt", hif.stall_cycles, 32'd4);
`else
      check("dir_stall_cnt", hif.stall_cycles, 32'd0);
`endif
      @(negedge clk);

      // Reset one cycle into an op aborts it without an mc_done pulse.
      hif.mc_start_e = 1;
      step(); @(negedge clk);
      rst = 0;
      step(); check("dir_rst_mid", 32'(ctrl_obs()), 32'd0); @(negedge clk);
      rst = 1; hif.mc_start_e = 0;
      for (int i = 0; i < MC; i++) begin
         step(); check("dir_rst_no_done", 32'(ctrl_obs()), 32'd0); @(negedge clk);
      end

      // Randomized traffic with narrow register ranges to produce frequent hazards.
      for (int i = 0; i < 600; i++) begin
         rst             = ($urandom_range(0, 49) != 0);
         hif.rs1_d       = 5'($urandom_range(0, 3));
         hif.rs2_d       = 5'($urandom_range(0, 3));
         hif.rs1_e       = 5'($urandom_range(0, 3));
         hif.rs2_e       = 5'($urandom_range(0, 3));
         hif.rd_e        = 5'($urandom_range(0, 3));
         hif.rd_m        = 5'($urandom_range(0, 3));
         hif.rd_w        = 5'($urandom_range(0, 3));
         hif.reg_write_m = 1'($urandom);
         hif.reg_write_w = 1'($urandom);
         hif.load_e      = 1'($urandom);
         hif.pc_src_e    = ($urandom_range(0, 3) == 0);
         hif.mc_start_e  = ($urandom_range(0, 7) == 0);
         step(); @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
